act_writeback: RTL and testbench
================================

// Module: act_writeback
// PURPOSE
//   Write-back end of the layer datapath. Captures one layer's parallel PE accumulator
//   results (lanes 0..N_LANES-1), applies optional ReLU, then streams them one word per
//   handshake to a memory-bank write port at base_addr+idx.
//   Mirror of the input-side reader that fetches one activation per cycle by incrementing
//   address; feeds the next layer's input region.
// PARAMETERS
//   N_LANES  32  number of accumulator lanes captured per layer pass
//   DATA_W   16  width of one accumulator result / memory word
//   ADDR_W   10  memory word-address width
//   CNT_W    6   width of lane count, = $clog2(N_LANES+1)
// PORTS
//   clk        in   1               clock
//   rst        in   1               synchronous, active-high reset
//   cap_en     in   1               capture request; accepted only when cap_ready=1
//   cap_ready  out  1               block idle, can accept capture
//   acc_flat   in   N_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed
//   relu_en    in   1               1 = clamp negative lanes to 0 at capture
//   base_addr  in   ADDR_W          destination address of lane 0
//   lane_cnt   in   CNT_W           number of lanes to write (lanes 0..lane_cnt-1)
//   wr_valid   out  1               write word valid
//   wr_ready   in   1               memory accepts word this cycle
//   wr_addr    out  ADDR_W          write address
//   wr_data    out  DATA_W          write data
//   busy       out  1               capture held, stream not finished
//   done       out  1               one-cycle pulse after last word accepted
// BEHAVIOUR
//   - Reset: state=IDLE, idx=0, cap_ready=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0,
//     done=0. Reset mid-stream aborts immediately; remaining words are never written.
//   - FSM: IDLE -> STREAM -> DONE -> IDLE.
//   - IDLE: cap_ready=1. On cap_en=1, latch in one cycle:
//       - all lanes; with relu_en=1, a lane with MSB=1 is stored as 0.
//       - base_addr and effective count.
//     Then set idx=0 and go to STREAM.
//   - Effective count: lane_cnt=0 or lane_cnt>N_LANES is treated as N_LANES.
//   - Capture is registered: cap_en high in cycle t gives wr_valid=1 in cycle t+1.
//     acc_flat is don't-care after the capture cycle.
//   - STREAM: wr_valid=1, wr_data=lane[idx], wr_addr=(base+idx) mod 2^ADDR_W.
//     Addresses wrap silently past 2^ADDR_W-1.
//   - Handshake:
//       - A word transfers when wr_valid & wr_ready. idx advances only on transfer.
//       - While wr_ready=0, wr_addr and wr_data are held stable.
//       - Full throughput is one word per cycle when wr_ready is held at 1.
//   - Last transfer (idx==count-1 accepted in cycle t):
//       - wr_valid=0 in t+1; state DONE in t+1 with done=1.
//       - IDLE in t+2 with cap_ready=1.
//   - busy=1 in STREAM and DONE; cap_ready=~busy.
//   - cap_en while busy is ignored and no state changes; it is not queued.
//   - Stored lanes >= count are never output.
//   - ReLU is applied only at capture. Lane data is never altered during STREAM.
// TESTING
//   1. Full layer, no stall:
//        base=0x100, lane_cnt=32, relu_en=0, lane i = i*3, wr_ready=1.
//        -> 32 consecutive writes, addr 0x100..0x11F, data 0,3..93.
//        -> done one cycle after last write.
//   2. ReLU:
//        lanes alternate 0xFFF0/0x0005, relu_en=1, lane_cnt=4.
//        -> data 0,5,0,5.
//      Repeat with relu_en=0.
//        -> data 0xFFF0,0x0005,0xFFF0,0x0005.
//   3. Backpressure:
//        wr_ready toggled 1,0,0,1,... during stream.
//        -> addr/data held across stalls; no word duplicated or skipped.
//        -> done only after the 32nd accepted word.
//   4. Wrap and count edges:
//        base=0x3FE, lane_cnt=3 -> addr 0x3FE,0x3FF,0x000.
//        lane_cnt=0 -> 32 words written.
//   5. Capture while busy:
//        cap_en pulsed mid-stream with different acc_flat.
//        -> ignored; original data streams.
//        New cap_en in the first IDLE cycle after done is accepted.
//   6. Reset mid-stream:
//        rst asserted after word 10.
//        -> next cycle wr_valid=0, busy=0, cap_ready=1, done never pulses.

Source files
------------

// File: rtl/act_writeback.sv
// Layer write-back: captures all PE accumulator lanes in one cycle, applies optional ReLU,
// then streams lanes 0..count-1 to a memory write port at consecutive addresses.
module act_writeback #(
  parameter int unsigned N_LANES = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_en,
  output logic                      cap_ready,
  input  logic [N_LANES*DATA_W-1:0] acc_flat,
  input  logic                      relu_en,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          lane_cnt,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   lanes_q [N_LANES];
  logic [DATA_W-1:0]   cap_lanes [N_LANES];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    idx_q;
  logic [CNT_W-1:0]    idx_d;
  logic [CNT_W-1:0]    eff_cnt;
  logic                last_word;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                busy_q;
  logic                done_q;

  always_comb begin
    for (int unsigned i = 0; i < N_LANES; i++) begin
      cap_lanes[i] = (relu_en && acc_flat[i*DATA_W + DATA_W - 1]) ? '0
                                                                   : acc_flat[i*DATA_W +: DATA_W];
    end
  end

  // A zero or oversized lane count means "the whole layer".
  assign eff_cnt   = (lane_cnt == '0 || lane_cnt > CNT_W'(N_LANES)) ? CNT_W'(N_LANES) : lane_cnt;
  assign idx_d     = idx_q + CNT_W'(1);
  assign last_word = (idx_q == cnt_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cap_en) begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lanes_q[i] <= cap_lanes[i];
      end
    end
  end

  // Lane 0 is presented straight from the capture path so the first word is valid
  // in the cycle after capture; later words come from the stored lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cap_en) begin
            state_q    <= S_STREAM;
            idx_q      <= '0;
            cnt_q      <= eff_cnt;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= base_addr;
            wr_data_q  <= cap_lanes[0];
            busy_q     <= 1'b1;
          end
        end
        S_STREAM: begin
          if (wr_ready) begin
            if (last_word) begin
              state_q    <= S_DONE;
              wr_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              wr_addr_q <= wr_addr_q + ADDR_W'(1);
              wr_data_q <= lanes_q[idx_d[IDX_W-1:0]];
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cap_ready = ~busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_act_writeback.sv
// Self-checking bench for act_writeback: randomized layers scored against a queue-based
// model of the expected write stream, with a negedge monitor recording transfers.
module tb_act_writeback;
  localparam int N  = 32;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_en = 1'b0;
  logic          cap_ready;
  logic [N*DW-1:0] acc_flat = '0;
  logic          relu_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] lane_cnt = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  act_writeback #(.N_LANES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cap_ready(cap_ready), .acc_flat(acc_flat),
    .relu_en(relu_en), .base_addr(base_addr), .lane_cnt(lane_cnt), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  logic [DW-1:0] lanes [N];
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  int ncyc = 0, first_cyc = -1, last_cyc = -1, done_cnt = 0, done_cyc = -1;
  int hold_viol = 0, cap_cyc = 0, rdy_mode = 0, pat = 0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  // Monitor: records accepted words, done pulses and any change during a stall.
  always @(negedge clk) begin
    ncyc++;
    if (prev_stall && !(wr_valid === 1'b1 && wr_addr === prev_addr && wr_data === prev_data))
      hold_viol++;
    prev_stall = wr_valid && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    if (wr_valid && wr_ready) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      if (first_cyc < 0) first_cyc = ncyc;
      last_cyc = ncyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  // Memory-side ready: always on, 1-0-0 repeating, or random.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: wr_ready = 1'b1;
      1: begin wr_ready = (pat % 3 == 0); pat++; end
      default: wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic clear_mon();
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    first_cyc = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1; hold_viol = 0;
  endtask

  // Reference model: the words a layer should produce, in order.
  task automatic build_exp(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input logic relu);
    int eff;
    eff = (cnt == 0 || int'(cnt) > N) ? N : int'(cnt);
    for (int i = 0; i < eff; i++) begin
      exp_addr.push_back(AW'(int'(base) + i));
      exp_data.push_back((relu && lanes[i][DW-1]) ? '0 : lanes[i]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) return i;
    if (obs_addr.size() != exp_addr.size()) return n;
    return -1;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) lanes[i] = DW'($urandom);
  endtask

  task automatic start_layer(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input logic relu);
    clear_mon();
    build_exp(base, cnt, relu);
    for (int i = 0; i < N; i++) acc_flat[i*DW +: DW] = lanes[i];
    base_addr = base; lane_cnt = cnt; relu_en = relu; cap_en = 1'b1;
    @(posedge clk); #1;
    cap_en = 1'b0;
    cap_cyc = ncyc;
    for (int i = 0; i < N; i++) acc_flat[i*DW +: DW] = DW'($urandom);
    base_addr = AW'($urandom); lane_cnt = CW'($urandom); relu_en = 1'($urandom);
  endtask

  // Returns at the negedge where done is high (DUT in DONE).
  task automatic wait_layer();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: done not seen, got %0d pulses, required 1 within 400 cycles", done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    tests += 6;
    if (cap_ready !== 1'b1) begin fails++; $display("FAIL reset_cap_ready: got %b need 1", cap_ready); end
    if (wr_valid !== 1'b0)  begin fails++; $display("FAIL reset_wr_valid: got %b need 0", wr_valid); end
    if (wr_addr !== '0)     begin fails++; $display("FAIL reset_wr_addr: got %h need 000", wr_addr); end
    if (wr_data !== '0)     begin fails++; $display("FAIL reset_wr_data: got %h need 0000", wr_data); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b need 0", done); end
  endtask

  task automatic test_full_no_stall();
    int d;
    for (int i = 0; i < N; i++) lanes[i] = DW'(i * 3);
    rdy_mode = 0;
    start_layer(10'h100, 6'd32, 1'b0);
    wait_layer();
    tests += 3;
    if (busy !== 1'b1 || cap_ready !== 1'b0) begin
      fails++; $display("FAIL full_done_state: busy=%b cap_ready=%b need 1/0", busy, cap_ready);
    end
    d = first_diff();
    if (d != -1) begin
      fails++;
      $display("FAIL full_stream: word %0d got %0d words addr %h data %h, need %0d words addr %h data %h",
               d, obs_addr.size(), obs_addr[d], obs_data[d], exp_addr.size(), exp_addr[d], exp_data[d]);
    end
    if (first_cyc != cap_cyc + 1 || last_cyc != cap_cyc + 32 || done_cyc != cap_cyc + 33) begin
      fails++;
      $display("FAIL full_timing: first/last/done cycle %0d/%0d/%0d, need %0d/%0d/%0d",
               first_cyc, last_cyc, done_cyc, cap_cyc + 1, cap_cyc + 32, cap_cyc + 33);
    end
    @(negedge clk); #1;
    tests++;
    if (cap_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL full_idle_after: cap_ready=%b busy=%b done=%b need 1/0/0", cap_ready, busy, done);
    end
  endtask

  task automatic test_relu();
    int d;
    logic r;
    for (int i = 0; i < N; i++) lanes[i] = (i % 2 == 1) ? 16'h0005 : 16'hFFF0;
    rdy_mode = 0;
    for (int pass = 0; pass < 6; pass++) begin
      r = (pass == 0) ? 1'b1 : (pass == 1) ? 1'b0 : 1'($urandom);
      if (pass < 2) start_layer(10'h040, 6'd4, r);
      else begin
        rand_lanes();
        rdy_mode = 2;
        start_layer(AW'($urandom), CW'($urandom_range(1, 32)), r);
      end
      wait_layer();
      d = first_diff();
      tests++;
      if (d != -1) begin
        fails++;
        $display("FAIL relu_stream[%0d]: relu=%b word %0d got %0d words data %h addr %h, need %0d words data %h addr %h",
                 pass, r, d, obs_data.size(), obs_data[d], obs_addr[d], exp_data.size(), exp_data[d], exp_addr[d]);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int d;
    rand_lanes();
    rdy_mode = 1; pat = 0;
    start_layer(AW'($urandom), 6'd32, 1'b0);
    wait_layer();
    d = first_diff();
    tests += 3;
    if (hold_viol != 0) begin fails++; $display("FAIL bp_hold: %0d stall violations, need 0", hold_viol); end
    if (d != -1) begin
      fails++;
      $display("FAIL bp_stream: word %0d got %0d words addr %h data %h, need %0d words addr %h data %h",
               d, obs_addr.size(), obs_addr[d], obs_data[d], exp_addr.size(), exp_addr[d], exp_data[d]);
    end
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      fails++; $display("FAIL bp_done: %0d pulses at cycle %0d, need 1 at cycle %0d", done_cnt, done_cyc, last_cyc + 1);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_wrap_counts();
    int d;
    logic [AW-1:0] b [4];
    logic [CW-1:0] c [4];
    b[0] = 10'h3FE; c[0] = 6'd3;
    b[1] = AW'($urandom); c[1] = 6'd0;
    b[2] = AW'($urandom); c[2] = CW'($urandom_range(33, 63));
    b[3] = 10'h3FF; c[3] = 6'd1;
    rdy_mode = 0;
    for (int t = 0; t < 4; t++) begin
      rand_lanes();
      start_layer(b[t], c[t], 1'b0);
      wait_layer();
      d = first_diff();
      tests += 2;
      if (d != -1) begin
        fails++;
        $display("FAIL wrap_stream[%0d]: word %0d got %0d words addr %h data %h, need %0d words addr %h data %h",
                 t, d, obs_addr.size(), obs_addr[d], obs_data[d], exp_addr.size(), exp_addr[d], exp_data[d]);
      end
      if (done_cyc != last_cyc + 1) begin
        fails++; $display("FAIL wrap_done[%0d]: done at %0d, need %0d", t, done_cyc, last_cyc + 1);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_capture_busy();
    int d;
    rand_lanes();
    rdy_mode = 1; pat = 0;
    start_layer(10'h200, 6'd20, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) acc_flat[i*DW +: DW] = ~lanes[i];
    base_addr = 10'h000; lane_cnt = 6'd5; relu_en = 1'b1; cap_en = 1'b1;
    @(posedge clk); #1 cap_en = 1'b0;
    wait_layer();
    d = first_diff();
    tests += 2;
    if (d != -1) begin
      fails++;
      $display("FAIL busy_ignore: word %0d got %0d words addr %h data %h, need %0d words addr %h data %h",
               d, obs_addr.size(), obs_addr[d], obs_data[d], exp_addr.size(), exp_addr[d], exp_data[d]);
    end
    if (done_cnt != 1) begin fails++; $display("FAIL busy_done_cnt: got %0d need 1", done_cnt); end
    @(negedge clk); #1;
    rand_lanes();
    rdy_mode = 0;
    start_layer(10'h0F0, 6'd7, 1'b1);
    @(negedge clk); #1;
    tests++;
    if (wr_valid !== 1'b1 || first_cyc != cap_cyc + 1) begin
      fails++; $display("FAIL first_idle_capture: wr_valid=%b first=%0d need 1/%0d", wr_valid, first_cyc, cap_cyc + 1);
    end
    wait_layer();
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL first_idle_stream: word %0d got %0d words data %h, need %0d words data %h",
               d, obs_data.size(), obs_data[d], exp_data.size(), exp_data[d]);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    rand_lanes();
    rdy_mode = 0;
    start_layer(10'h010, 6'd32, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk); #1;
      if (obs_addr.size() >= 10) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rstmid_timeout: got %0d words need 10", obs_addr.size()); end
    rst = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || cap_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: valid=%b busy=%b cap_ready=%b done=%b need 0/0/1/0", wr_valid, busy, cap_ready, done);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    tests += 2;
    if (done_cnt != 0) begin fails++; $display("FAIL rstmid_done: got %0d pulses need 0", done_cnt); end
    if (obs_addr.size() != 10) begin fails++; $display("FAIL rstmid_words: got %0d words need 10", obs_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_full_no_stall();
    test_relu();
    test_backpressure();
    test_wrap_counts();
    test_capture_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
